// File: rtl/alu_issue.sv
// alu_issue: ID/EX pipeline register feeding the combinational ALU.
// Accepts decoded instructions over valid/ready, resolves RAW hazards by
// forwarding from EX (alu_y of the leaving instruction) and from write-back,
// and holds the registered A/B/F operands plus destination metadata.

// One forwarding mux per source operand.
module alu_issue_fwd #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] idx,
  input  logic [WIDTH-1:0] rf_val,
  input  logic             ex_en,
  input  logic [RADDR-1:0] ex_rd,
  input  logic [WIDTH-1:0] ex_y,
  input  logic             wb_wen,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] val
);
  // Priority: r0, EX result, write-back, register file.
  always_comb begin
    val = rf_val;
    if (idx == '0)                     val = '0;
    else if (ex_en && (ex_rd == idx))  val = ex_y;
    else if (wb_wen && (wb_rd == idx)) val = wb_data;
  end
endmodule

module alu_issue #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_f,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_wen,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             wb_wen,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  output logic [RADDR-1:0] out_rd,
  output logic             out_wen,
  output logic [31:0]      issue_cnt
);
  localparam int NSRC = 2; // 0: rs, 1: rt

  logic                       vld_q;
  logic [WIDTH-1:0]           a_q, b_q;
  logic [2:0]                 f_q;
  logic [RADDR-1:0]           rd_q;
  logic                       wen_q;
  logic [31:0]                cnt_q;

  logic [NSRC-1:0][RADDR-1:0] src_idx;
  logic [NSRC-1:0][WIDTH-1:0] src_rf;
  logic [NSRC-1:0][WIDTH-1:0] src_fwd;
  logic                       accept;
  logic                       leave;
  logic                       ex_en;

  assign src_idx  = {in_rt, in_rs};
  assign src_rf   = {in_rt_val, in_rs_val};
  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign leave    = vld_q && out_ready;
  // A held instruction can only forward when it is leaving; accept implies that.
  assign ex_en    = vld_q && wen_q;

  genvar s;
  generate
    for (s = 0; s < NSRC; s++) begin : g_src
      alu_issue_fwd #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd (
        .idx    (src_idx[s]),
        .rf_val (src_rf[s]),
        .ex_en  (ex_en),
        .ex_rd  (rd_q),
        .ex_y   (alu_y),
        .wb_wen (wb_wen),
        .wb_rd  (wb_rd),
        .wb_data(wb_data),
        .val    (src_fwd[s])
      );
    end
  endgenerate

  // Pipeline register: flush beats accept beats leave; otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      f_q   <= 3'b000;
      rd_q  <= '0;
      wen_q <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
      wen_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      a_q   <= src_fwd[0];
      b_q   <= in_use_imm ? in_imm : src_fwd[1];
      f_q   <= in_f;
      rd_q  <= in_rd;
      wen_q <= in_wen;
      cnt_q <= cnt_q + 32'd1;
    end else if (leave) begin
      vld_q <= 1'b0;
      wen_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;
  assign out_rd    = rd_q;
  assign out_wen   = wen_q;
  assign issue_cnt = cnt_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven vectors through a scoreboard queue, plus
// hand sequences for backpressure, flush, counter wrap and async reset.
module tb_alu_issue;
  localparam int W = 32;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid, in_ready;
  logic [R-1:0] in_rs, in_rt, in_rd, wb_rd, out_rd;
  logic [W-1:0] in_rs_val, in_rt_val, in_imm, alu_y, wb_data, alu_a, alu_b;
  logic         in_use_imm, in_wen, wb_wen, out_ready, flush, out_valid, out_wen;
  logic [2:0]   in_f, alu_f;
  logic [31:0]  issue_cnt;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(W), .RADDR(R)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_f(in_f), .in_rd(in_rd),
    .in_wen(in_wen), .alu_y(alu_y), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_ready(out_ready), .flush(flush),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .out_rd(out_rd), .out_wen(out_wen), .issue_cnt(issue_cnt)
  );

  // Reference ALU downstream of the stage.
  always_comb begin
    case (alu_f)
      3'b010:  alu_y = alu_a + alu_b;
      3'b110:  alu_y = alu_a - alu_b;
      3'b000:  alu_y = alu_a & alu_b;
      3'b001:  alu_y = alu_a | alu_b;
      3'b111:  alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = '0;
    endcase
  end

  typedef struct {
    logic [R-1:0] rs, rt, rd, wb_rd;
    logic [W-1:0] rs_val, rt_val, imm, wb_data, exp_a, exp_b;
    logic         use_imm, wen, wb_wen;
    logic [2:0]   f;
  } vec_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic [2:0]   f;
    logic [R-1:0] rd;
    logic         wen;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  vec_t        tbl[8];
  vec_t        v;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt;

  function automatic vec_t mk(int rs, int rs_val, int rt, int rt_val,
                              logic use_imm, logic [31:0] imm, logic [2:0] f,
                              int rd, logic wen, logic wbw, int wbr, int wbd,
                              logic [31:0] ea, logic [31:0] eb);
    vec_t t;
    t.rs = R'(rs); t.rs_val = W'(rs_val); t.rt = R'(rt); t.rt_val = W'(rt_val);
    t.use_imm = use_imm; t.imm = imm; t.f = f; t.rd = R'(rd); t.wen = wen;
    t.wb_wen = wbw; t.wb_rd = R'(wbr); t.wb_data = W'(wbd);
    t.exp_a = ea; t.exp_b = eb;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    in_valid = 1'b1; in_rs = t.rs; in_rt = t.rt; in_rs_val = t.rs_val;
    in_rt_val = t.rt_val; in_imm = t.imm; in_use_imm = t.use_imm; in_f = t.f;
    in_rd = t.rd; in_wen = t.wen; wb_wen = t.wb_wen; wb_rd = t.wb_rd;
    wb_data = t.wb_data;
  endtask

  task automatic push(vec_t t);
    exp_t e;
    e.a = t.exp_a; e.b = t.exp_b; e.f = t.f; e.rd = t.rd; e.wen = t.wen;
    sb.push_back(e);
    exp_cnt = exp_cnt + 32'd1;
  endtask

  // Pop the oldest expectation and compare it with the held instruction.
  task automatic expect_out(string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    last = e;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_a"}, alu_a, e.a);
    chk({nm, "_b"}, alu_b, e.b);
    chk({nm, "_f"}, 32'(alu_f), 32'(e.f));
    chk({nm, "_rd"}, 32'(out_rd), 32'(e.rd));
    chk({nm, "_wen"}, 32'(out_wen), 32'(e.wen));
    chk({nm, "_cnt"}, issue_cnt, exp_cnt);
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_wen = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rs rsv   rt rtv   imm? imm            f       rd wen wbw wbr wbd   exp_a         exp_b
    tbl[0] = mk(1, 5,    2, 7,    0, 32'h0,         3'b010, 3, 1, 0, 0, 0,    32'd5,        32'd7);
    tbl[1] = mk(3, 0,    1, 5,    0, 32'h0,         3'b110, 5, 1, 0, 0, 0,    32'd12,       32'd5);
    tbl[2] = mk(0, 'h99, 0, 3,    1, 32'h11,        3'b001, 4, 1, 1, 0, 'hFF, 32'h0,        32'h11);
    tbl[3] = mk(4, 'h33, 2, 7,    0, 32'h0,         3'b010, 6, 1, 1, 4, 'h22, 32'h11,       32'd7);
    tbl[4] = mk(4, 'h33, 6, 1,    0, 32'h0,         3'b000, 7, 0, 1, 4, 'h22, 32'h22,       32'h18);
    tbl[5] = mk(7, 'h44, 2, 7,    1, 32'hFFFF_FFFF, 3'b111, 8, 1, 1, 2, 'h55, 32'h44,       32'hFFFF_FFFF);
    tbl[6] = mk(8, 'h66, 8, 'h67, 0, 32'h0,         3'b110, 9, 1, 0, 0, 0,    32'h0,        32'h0);
    tbl[7] = mk(5, 1,    3, 'hAB, 0, 32'h0,         3'b010, 0, 1, 1, 5, 'h77, 32'h77,       32'hAB);

    rstn = 1'b0; out_ready = 1'b1; exp_cnt = '0;
    idle();
    drive(mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_f", 32'(alu_f), 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_wen", 32'(out_wen), 0);
    chk("rst_cnt", issue_cnt, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk) rstn = 1'b1;

    // Back-to-back issue through the table, out_ready held high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      out_ready = 1'b1;
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
      push(tbl[i]);
      @(posedge clk); #1;
      expect_out($sformatf("vec%0d", i));
    end

    // Backpressure: held instruction and counter freeze for 3 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    v = mk(2, 'h123, 1, 9, 0, 32'h0, 3'b010, 10, 1, 0, 0, 0, 32'h123, 32'd9);
    drive(v);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("bp%0d_a", k), alu_a, last.a);
      chk($sformatf("bp%0d_b", k), alu_b, last.b);
      chk($sformatf("bp%0d_f", k), 32'(alu_f), 32'(last.f));
      chk($sformatf("bp%0d_rd", k), 32'(out_rd), 32'(last.rd));
      chk($sformatf("bp%0d_cnt", k), issue_cnt, exp_cnt);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_in_ready", 32'(in_ready), 1);
    push(v);
    @(posedge clk); #1;
    expect_out("bp_rel");

    // Flush with an acceptable incoming instruction: nothing issues.
    @(negedge clk);
    flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_wen", 32'(out_wen), 0);
    chk("fl_cnt", issue_cnt, exp_cnt);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("fl_idle_valid", 32'(out_valid), 0);

    // Single issue then leave with nothing behind it.
    @(negedge clk);
    v = mk(3, 'h10, 0, 0, 0, 32'h0, 3'b001, 11, 1, 0, 0, 0, 32'h10, 32'h0);
    drive(v);
    push(v);
    @(posedge clk); #1;
    expect_out("single");
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("leave_valid", 32'(out_valid), 0);
    chk("leave_wen", 32'(out_wen), 0);

    // Counter wrap from all-ones.
    @(negedge clk);
    dut.cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    v = mk(1, 1, 1, 2, 0, 32'h0, 3'b010, 12, 1, 0, 0, 0, 32'd1, 32'd2);
    drive(v);
    push(v);
    @(posedge clk); #1;
    expect_out("wrap");

    // Asynchronous reset between edges with an instruction held.
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    @(posedge clk); #3;
    chk("pre_arst_valid", 32'(out_valid), 1);
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_cnt", issue_cnt, 0);
    chk("arst_a", alu_a, 0);
    chk("arst_wen", 32'(out_wen), 0);
    @(negedge clk) rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
